// File: rtl/edge_detect_pkg.sv
// Shared types and constants for the multi-channel debounced edge detector.
// Optional auto-repeat is compiled in with the EDGE_REPEAT_EN macro.
package edge_detect_pkg;

    localparam int CNT_W     = 8;
    localparam int MODE_RISE = 0;
    localparam int MODE_FALL = 1;
    localparam int MODE_BOTH = 2;

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        RISE_PEND = 2'b01,
        HIGH      = 2'b10,
        FALL_PEND = 2'b11
    } state_t;

    // True when an accepted edge of the given direction should pulse z.
    function automatic logic edge_match(input int mode, input logic rising);
        return (mode == MODE_BOTH) || (rising ? (mode == MODE_RISE) : (mode == MODE_FALL));
    endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One debounce channel: 4-state FSM, shared 8-bit tick counter, registered z/level.
// Auto-repeat while the active level is held exists only with EDGE_REPEAT_EN defined.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int MODE          = MODE_RISE,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic w,
    output logic z,
    output logic level
);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255 || MODE < MODE_RISE || MODE > MODE_BOTH) begin : g_bad_param
        $error("edge_detect_chan: parameter out of legal range");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             z_reg, z_next;
    logic             level_reg, level_next;

`ifdef EDGE_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // first_reg: initial delay already elapsed; fallen_reg: LOW has been reached by a debounced fall.
    logic first_reg, first_next;
    logic fallen_reg, fallen_next;
    logic active_hold;
    logic [CNT_W-1:0] rep_last;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        z_next     = 1'b0;
        level_next = level_reg;

        case (state_reg)
            LOW: begin
                if (w) begin
                    state_next = RISE_PEND;
                    cnt_next   = '0;
                end
            end
            RISE_PEND: begin
                if (!w) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else if (en) begin
                    if (cnt_reg == DEB_LAST) begin
                        state_next = HIGH;
                        level_next = 1'b1;
                        cnt_next   = '0;
                        z_next     = edge_match(MODE, 1'b1);
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!w) begin
                    state_next = FALL_PEND;
                    cnt_next   = '0;
                end
            end
            FALL_PEND: begin
                if (w) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (en) begin
                    if (cnt_reg == DEB_LAST) begin
                        state_next = LOW;
                        level_next = 1'b0;
                        cnt_next   = '0;
                        z_next     = edge_match(MODE, 1'b0);
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = LOW;
                cnt_next   = '0;
            end
        endcase

`ifdef EDGE_REPEAT_EN
        // Holding the active level reuses cnt as the repeat timer; a state change restarts it.
        active_hold = (state_reg == HIGH && w && MODE != MODE_FALL) ||
                      (state_reg == LOW && !w && MODE == MODE_FALL && fallen_reg);
        rep_last    = first_reg ? PER_LAST : DLY_LAST;
        first_next  = (state_next != state_reg) ? 1'b0 : first_reg;
        fallen_next = fallen_reg | (state_reg == FALL_PEND && state_next == LOW);
        if (active_hold && en) begin
            if (cnt_reg == rep_last) begin
                z_next     = 1'b1;
                cnt_next   = '0;
                first_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= LOW;
            cnt_reg    <= '0;
            z_reg      <= 1'b0;
            level_reg  <= 1'b0;
`ifdef EDGE_REPEAT_EN
            first_reg  <= 1'b0;
            fallen_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            z_reg      <= z_next;
            level_reg  <= level_next;
`ifdef EDGE_REPEAT_EN
            first_reg  <= first_next;
            fallen_reg <= fallen_next;
`endif
        end
    end

    assign z     = z_reg;
    assign level = level_reg;

endmodule

// File: rtl/edge_detect_bank.sv
// CH independent debounced edge detectors sharing one enable tick.
// Auto-repeat pulses are available when built with EDGE_REPEAT_EN.
module edge_detect_bank
    import edge_detect_pkg::*;
#(
    parameter int CH            = 4,
    parameter int DEB_CYCLES    = 4,
    parameter int MODE          = MODE_RISE,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] w,
    output logic [CH-1:0] z,
    output logic [CH-1:0] level
);

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        edge_detect_chan #(
            .DEB_CYCLES   (DEB_CYCLES),
            .MODE         (MODE),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .w    (w[gi]),
            .z    (z[gi]),
            .level(level[gi])
        );
    end

endmodule

// File: tb/tb_edge_detect_bank.sv
// Bench: three banks (MODE 0/1/2) on shared inputs, checked every cycle against a
// level/pending-tick model, plus directed literal checks on the documented scenarios.
module tb_edge_detect_bank;

    localparam int CH  = 4;
    localparam int DEB = 4;
    localparam int RD  = 16;
    localparam int RP  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [CH-1:0] w   = '0;
    logic [CH-1:0] dz [0:2];
    logic [CH-1:0] dl [0:2];

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        edge_detect_bank #(
            .CH(CH), .DEB_CYCLES(DEB), .MODE(gi), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .w(w), .z(dz[gi]), .level(dl[gi])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a level change is accepted once w has disagreed with the accepted level
    // continuously for DEB enabled ticks after the cycle it first disagreed.
    bit m_lvl [0:2][0:CH-1];
    bit m_pend[0:2][0:CH-1];
    int m_tk  [0:2][0:CH-1];
    bit m_z   [0:2][0:CH-1];
    bit m_fall[0:2][0:CH-1];
    bit m_act [0:2][0:CH-1];
    int m_rc  [0:2][0:CH-1];

    function automatic bit pulses_on(input int mode, input bit rising);
        return mode == 2 || (rising ? mode == 0 : mode == 1);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < CH; c++) begin
                if (rst) begin
                    m_lvl[d][c] = 0; m_pend[d][c] = 0; m_tk[d][c] = 0; m_z[d][c] = 0;
                    m_fall[d][c] = 0; m_act[d][c] = 0; m_rc[d][c] = 0;
                end else begin
                    bit zz;
                    bit now_act;
                    zz = 0;
                    if (w[c] != m_lvl[d][c]) begin
                        if (!m_pend[d][c]) begin
                            m_pend[d][c] = 1;
                            m_tk[d][c] = 0;
                        end else if (en) begin
                            m_tk[d][c]++;
                            if (m_tk[d][c] == DEB) begin
                                m_lvl[d][c] = w[c];
                                m_pend[d][c] = 0;
                                zz = pulses_on(d, w[c]);
                                if (!w[c]) m_fall[d][c] = 1;
                            end
                        end
                    end else begin
                        m_pend[d][c] = 0;
                    end
`ifdef EDGE_REPEAT_EN
                    now_act = !m_pend[d][c] && (m_lvl[d][c] == (d != 1)) && (d != 1 || m_fall[d][c]);
                    if (now_act && m_act[d][c]) begin
                        if (en) begin
                            m_rc[d][c]++;
                            if (m_rc[d][c] == RD || (m_rc[d][c] > RD && (m_rc[d][c] - RD) % RP == 0))
                                zz = 1;
                        end
                    end else if (now_act) begin
                        m_rc[d][c] = 0;
                    end
                    m_act[d][c] = now_act;
`else
                    now_act = 0;
                    m_act[d][c] = now_act;
`endif
                    m_z[d][c] = zz;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 3; d++) begin
                logic [CH-1:0] ez, el;
                for (int c = 0; c < CH; c++) begin
                    ez[c] = m_z[d][c];
                    el[c] = m_lvl[d][c];
                end
                check($sformatf("model_z_mode%0d", d), int'(dz[d]), int'(ez));
                check($sformatf("model_level_mode%0d", d), int'(dl[d]), int'(el));
            end
        end
    end

    // Apply inputs, let one rising edge happen, return shortly after it.
    task automatic cyc(input logic [CH-1:0] wv, input logic env, input logic rv);
        w = wv; en = env; rst = rv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses, first_k, ticks, acc;
        #1;
        for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1, 1'b1);
        checking = 1'b1;
        check("reset_level", int'(dl[0]), 0);
        check("reset_z", int'(dz[0]), 0);

        // Clean press on channel 0
        for (int k = 0; k < 10; k++) begin
            cyc(4'b0001, 1'b1, 1'b0);
            if (k < 4) check($sformatf("press_level_e%0d", k), int'(dl[0]), 0);
            if (k < 4) check($sformatf("press_z_e%0d", k), int'(dz[0]), 0);
            if (k == 4) check("press_level_e4", int'(dl[0]), 1);
            if (k == 4) check("press_z_e4", int'(dz[0]), 1);
            if (k == 5) check("press_z_e5", int'(dz[0]), 0);
        end
        for (int k = 0; k < 8; k++) cyc(4'b0000, 1'b1, 1'b0);
        check("release_level", int'(dl[0]), 0);
        $display("scenario clean_press done");

        // Bounce on channel 1: 3-cycle burst, gap, then held
        pulses = 0; first_k = -1;
        for (int k = 0; k < 16; k++) begin
            cyc((k == 3) ? 4'b0000 : 4'b0010, 1'b1, 1'b0);
            if (dz[0][1]) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_pulse_edge", first_k, 8);
        for (int k = 0; k < 8; k++) cyc(4'b0000, 1'b1, 1'b0);
        $display("scenario bounce done");

        // MODE 2 press and release on channel 2
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            cyc((k < 8) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
            if (dz[2][2]) pulses++;
        end
        check("both_pulses", pulses, 2);
        check("both_level_end", int'(dl[2][2]), 0);
        $display("scenario mode_both done");

        // Sparse enable on channel 3: tick every 10th cycle, never on the entry edge
        ticks = 0; acc = -1; pulses = 0;
        for (int k = 0; k < 50; k++) begin
            cyc(4'b1000, (k % 10) == 9, 1'b0);
            if (en) ticks++;
            if (dz[0][3]) pulses++;
            if (acc < 0 && dl[0][3]) acc = ticks;
        end
        check("sparse_accept_tick", acc, 4);
        check("sparse_pulses", pulses, 1);
        for (int k = 0; k < 8; k++) cyc(4'b0000, 1'b1, 1'b0);
        $display("scenario sparse_tick done");

        // Reset mid-RISE_PEND, then in HIGH
        cyc(4'b0001, 1'b1, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0001, 1'b1, 1'b1);
            check("rst_pend_level", int'(dl[0]), 0);
            check("rst_pend_z", int'(dz[0]), 0);
        end
        for (int k = 0; k < 6; k++) cyc(4'b0001, 1'b1, 1'b0);
        check("after_rst_level", int'(dl[0]), 1);
        cyc(4'b0001, 1'b1, 1'b1);
        check("rst_high_level", int'(dl[0]), 0);
        check("rst_high_z", int'(dz[0]), 0);
        for (int k = 0; k < 8; k++) cyc(4'b0000, 1'b1, 1'b0);
        $display("scenario reset done");

`ifdef EDGE_REPEAT_EN
        // Auto-repeat: acceptance at edge 4, then +16, then every 4 ticks
        for (int k = 0; k < 60; k++) begin
            cyc(4'b0001, 1'b1, 1'b0);
            check($sformatf("repeat_z_e%0d", k), int'(dz[0][0]),
                  int'(k == 4 || (k >= 20 && (k - 20) % 4 == 0)));
        end
        for (int k = 0; k < 8; k++) begin
            cyc(4'b0000, 1'b1, 1'b0);
            check("repeat_stop", int'(dz[0][0]), 0);
        end
        $display("scenario repeat done");
`endif

        // Random phase: sticky inputs, mixed tick density, rare reset
        for (int blk = 0; blk < 8; blk++) begin
            logic [CH-1:0] wv;
            wv = w;
            for (int k = 0; k < 500; k++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 5) == 0) wv[c] = ~wv[c];
                cyc(wv, (blk % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 299) == 0);
            end
            $display("random block %0d done", blk);
        end

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
